multi_port_interconnect: RTL and testbench
==========================================

MULTI_PORT_INTERCONNECT -- requirements
Module: multi_port_interconnect

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requester ports (2..8); port 0 is the data port, port 1 the instruction port.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width; fixed at 32.
REQ-004 Parameter MEM_LATENCY, default 1, cycles from mem_en to valid mem_rdata (1..15).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  NUM_PORTS  per-port request valid.
REQ-008 req_size  in  2*NUM_PORTS  per-port size; 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 req_addr  in  ADDR_W*NUM_PORTS  per-port byte address.
REQ-010 req_ready  out  NUM_PORTS  one-hot accept strobe.
REQ-011 resp_valid  out  NUM_PORTS  one-hot response strobe.
REQ-012 resp_data  out  DATA_W  response data, shared by all ports.
REQ-013 resp_err  out  1  response error flag, qualified by any resp_valid bit.
REQ-014 mem_en  out  1  memory read strobe.
REQ-015 mem_addr  out  ADDR_W  word-aligned memory address; bits [1:0] always 0.
REQ-016 mem_rdata  in  DATA_W  aligned memory word.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; one transaction in flight at most.
REQ-019 IDLE arbitration: round-robin; grant the first port with req_valid=1, searching from rr_ptr upward with wrap modulo NUM_PORTS.
REQ-020 req_ready[grant] is combinational and asserts only in IDLE; a handshake is req_valid & req_ready in the same cycle.
REQ-021 On handshake: latch grant, addr, size; next state ISSUE, or RESP with error when the request is illegal.
REQ-022 Illegal request: size 11; half with addr[0]=1; word with addr[1:0]!=00. No mem_en is issued for an illegal request.
REQ-023 ISSUE: mem_en=1 for exactly one cycle; mem_addr = {addr[ADDR_W-1:2],2'b00}; next state WAIT with counter = MEM_LATENCY.
REQ-024 WAIT: decrement the counter each cycle; in the cycle the counter equals 1, register mem_rdata and go to RESP.
REQ-025 Data extraction: byte = mem_rdata[8*addr[1:0] +: 8] zero-extended; half = mem_rdata[16*addr[1] +: 16] zero-extended; word = as is.
REQ-026 RESP: resp_valid[grant]=1 for exactly one cycle with resp_data and resp_err registered; next state IDLE.
REQ-027 RESP with error: resp_err=1 and resp_data=0.
REQ-028 On entry to RESP, rr_ptr = (grant+1) mod NUM_PORTS.
REQ-029 No grant is issued in the RESP cycle.
REQ-030 Latency: handshake at cycle T gives resp_valid at T+2+MEM_LATENCY for a legal request and at T+1 for an illegal one.
REQ-031 Requester duty: a requester holds valid, addr and size stable until req_ready. Deasserting before grant is legal and produces no response.
REQ-032 Inputs of a granted port are ignored after the handshake.
REQ-033 Simultaneous requests: exactly one grant per IDLE cycle; losers stay pending.
REQ-034 Fairness: a continuously requesting port is granted within NUM_PORTS transactions.

Reset
REQ-035 rst=1 forces immediately, without a clock edge: state IDLE, rr_ptr 0, counter 0, all outputs 0.
REQ-036 Reset mid-transaction aborts it with no resp_valid; after rst deasserts, the first grant follows the REQ-019 search from port 0.

Verification
REQ-037 Single port (NUM_PORTS=2, L=1): port0 word read at 0x10, mem_rdata=0xDEADBEEF, handshake at T -> mem_en at T+1 with mem_addr 0x10; resp_valid=01 at T+3 with data 0xDEADBEEF, err 0.
REQ-038 Byte/half extraction: mem_rdata=0xA1B2C3D4. Byte at 0x13 -> 0x000000A1. Half at 0x12 -> 0x0000A1B2.
REQ-039 Contention: both ports request continuously from reset -> grant order 0,1,0,1. Each handshake occurs in the cycle after the preceding response.
REQ-040 Illegal request: port1 word at 0x6 -> no mem_en; resp_valid=10 one cycle after handshake with err 1 and data 0.
REQ-041 Latency sweep L=4: handshake at T -> resp_valid at T+6, busy high T+1..T+6.
REQ-042 Reset during WAIT: assert rst -> outputs 0 immediately, no resp_valid. Requests after rst deasserts are granted starting from port 0.

Source files
------------

// File: rtl/multi_port_interconnect.sv
// Round-robin arbiter that serialises byte/half/word reads from several requesters
// onto a single fixed-latency memory read port, one transaction in flight at a time.
module multi_port_interconnect #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [2*NUM_PORTS-1:0]      req_size,
  input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        resp_err,
  output logic                        mem_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_reg;
  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [PTR_W-1:0]  grant_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic [3:0]        cnt_reg;
  logic [DATA_W-1:0] data_reg;
  logic              err_reg;

  logic [ADDR_W-1:0] port_addr [NUM_PORTS];
  logic [1:0]        port_size [NUM_PORTS];
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_found;
  logic              handshake;
  logic              illegal;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign port_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign port_size[gi] = req_size[gi*2 +: 2];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return sum[PTR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] word,
                                                input logic [1:0] size,
                                                input logic [1:0] offs);
    case (size)
      2'b00:   return {{(DATA_W-8){1'b0}}, word[{offs, 3'b000} +: 8]};
      2'b01:   return {{(DATA_W-16){1'b0}}, word[{offs[1], 4'b0000} +: 16]};
      default: return word;
    endcase
  endfunction

  // Search downward so the port closest to rr_ptr overwrites any farther match.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_valid[wrap_add(rr_ptr_reg, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(rr_ptr_reg, i);
      end
    end
  end

  always_comb begin
    case (port_size[grant_idx])
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = port_addr[grant_idx][0];
      2'b10:   illegal = |port_addr[grant_idx][1:0];
      default: illegal = 1'b1;
    endcase
  end

  // rst gates the strobe so it is low during reset even while a request is pending.
  assign handshake = (state_reg == S_IDLE) && grant_found && !rst;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state_reg == S_RESP) resp_valid[grant_reg] = 1'b1;
  end

  assign mem_en    = (state_reg == S_ISSUE);
  assign mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
  assign busy      = (state_reg != S_IDLE);
  assign resp_data = data_reg;
  assign resp_err  = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      addr_reg   <= '0;
      size_reg   <= '0;
      cnt_reg    <= '0;
      data_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (handshake) begin
            grant_reg <= grant_idx;
            addr_reg  <= port_addr[grant_idx];
            size_reg  <= port_size[grant_idx];
            if (illegal) begin
              data_reg   <= '0;
              err_reg    <= 1'b1;
              rr_ptr_reg <= wrap_add(grant_idx, 1);
              state_reg  <= S_RESP;
            end else begin
              state_reg <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt_reg   <= 4'(MEM_LATENCY);
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            data_reg   <= extract(mem_rdata, size_reg, addr_reg[1:0]);
            err_reg    <= 1'b0;
            rr_ptr_reg <= wrap_add(grant_reg, 1);
            state_reg  <= S_RESP;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_port_interconnect.sv
// Scoreboard bench: handshakes push hand-computed expectations, a monitor pops them
// when a response or memory strobe appears; a second instance checks latency 4.
module tb_multi_port_interconnect;

  localparam int NP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req_valid, req_ready, resp_valid;
  logic [2*NP-1:0] req_size;
  logic [32*NP-1:0] req_addr;
  logic [31:0]   resp_data, mem_addr, mem_rdata;
  logic          resp_err, mem_en, busy;

  logic [NP-1:0] req_valid4, req_ready4, resp_valid4;
  logic [2*NP-1:0] req_size4;
  logic [32*NP-1:0] req_addr4;
  logic [31:0]   resp_data4, mem_addr4;
  logic          resp_err4, mem_en4, busy4;
  logic [31:0]   mem_rdata4 = 32'h1234_5678;

  always #5 clk = ~clk;

  multi_port_interconnect #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_size(req_size), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy));

  multi_port_interconnect #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_size(req_size4), .req_addr(req_addr4),
    .req_ready(req_ready4), .resp_valid(resp_valid4), .resp_data(resp_data4), .resp_err(resp_err4),
    .mem_en(mem_en4), .mem_addr(mem_addr4), .mem_rdata(mem_rdata4), .busy(busy4));

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ma_q[$];
  int          hs_log[$];
  int          hs_cyc_log[$];
  int          resp_cyc_log[$];
  bit [31:0]   mem_tab [bit [31:0]];

  logic [31:0] exp_data [NP];
  logic        exp_err [NP];
  logic [31:0] exp_maddr [NP];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model with one cycle of read latency.
  always @(posedge clk)
    if (mem_en) mem_rdata <= mem_tab.exists(mem_addr) ? mem_tab[mem_addr] : 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Handshake observer: records grants and pushes the expectations set by the stimulus.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          exp_t e;
          e.port = p;
          e.data = exp_data[p];
          e.err  = exp_err[p];
          e.cyc  = cyc + (exp_err[p] ? 1 : 3);
          sb_q.push_back(e);
          if (!exp_err[p]) ma_q.push_back(exp_maddr[p]);
          hs_log.push_back(p);
          hs_cyc_log.push_back(cyc);
        end
      end
    end
  end

  // Monitor: compares every response and memory strobe against the queues.
  always @(negedge clk) begin
    if (resp_valid != '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", {62'b0, resp_valid}, 64'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_port", {62'b0, resp_valid}, 64'(1 << e.port));
        check("resp_data", {32'b0, resp_data}, {32'b0, e.data});
        check("resp_err", {63'b0, resp_err}, {63'b0, e.err});
        check("resp_cycle", 64'(cyc), 64'(e.cyc));
        resp_cyc_log.push_back(cyc);
      end
    end
    if (mem_en) begin
      if (ma_q.size() == 0) check("unexpected_mem_en", {63'b0, mem_en}, 64'h0);
      else check("mem_addr", {32'b0, mem_addr}, {32'b0, ma_q.pop_front()});
    end
  end

  task automatic set_port(input int p, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic e);
    exp_data[p]  = d;
    exp_err[p]   = e;
    exp_maddr[p] = {a[31:2], 2'b00};
    req_size[2*p +: 2]  = sz;
    req_addr[32*p +: 32] = a;
  endtask

  task automatic issue(input int p, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic e);
    int n;
    @(posedge clk); #1;
    set_port(p, sz, a, d, e);
    req_valid[p] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[p] && n < 50);
    check("handshake", {63'b0, req_ready[p]}, 64'h1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {63'b0, (n < 100)}, 64'h1);
  endtask

  initial begin
    int n;
    int t;
    rst = 1'b1;
    req_valid = '0; req_size = '0; req_addr = '0;
    req_valid4 = '0; req_size4 = '0; req_addr4 = '0;
    mem_rdata = '0;
    for (int p = 0; p < NP; p++) begin
      exp_data[p] = '0; exp_err[p] = 1'b0; exp_maddr[p] = '0;
    end
    mem_tab[32'h10] = 32'hDEAD_BEEF;
    mem_tab[32'h14] = 32'h0BAD_F00D;
    #2;
    check("rst_ctrl", {57'b0, req_ready, resp_valid, resp_err, mem_en, busy}, 64'h0);
    check("rst_data", {resp_data, mem_addr}, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Contention from reset: grants alternate, each right after the previous response.
    hs_log.delete(); hs_cyc_log.delete(); resp_cyc_log.delete();
    @(posedge clk); #1;
    set_port(0, 2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0);
    set_port(1, 2'b10, 32'h14, 32'h0BAD_F00D, 1'b0);
    req_valid = 2'b11;
    n = 0;
    while (hs_log.size() < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("contention_count", 64'(hs_log.size()), 64'd4);
    if (hs_log.size() == 4) begin
      check("grant0", 64'(hs_log[0]), 64'd0);
      check("grant1", 64'(hs_log[1]), 64'd1);
      check("grant2", 64'(hs_log[2]), 64'd0);
      check("grant3", 64'(hs_log[3]), 64'd1);
      for (int i = 1; i < 4; i++)
        check("back_to_back", 64'(hs_cyc_log[i]), 64'(resp_cyc_log[i-1] + 1));
    end
    wait_idle();

    // Single word read
    issue(0, 2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0);
    wait_idle();

    // Byte and half extraction
    mem_tab[32'h10] = 32'hA1B2_C3D4;
    issue(0, 2'b00, 32'h13, 32'h0000_00A1, 1'b0); wait_idle();
    issue(1, 2'b01, 32'h12, 32'h0000_A1B2, 1'b0); wait_idle();
    issue(0, 2'b00, 32'h10, 32'h0000_00D4, 1'b0); wait_idle();
    issue(1, 2'b00, 32'h11, 32'h0000_00C3, 1'b0); wait_idle();
    issue(0, 2'b01, 32'h10, 32'h0000_C3D4, 1'b0); wait_idle();

    // Illegal requests: error response one cycle after handshake, no memory strobe
    issue(1, 2'b10, 32'h06, 32'h0, 1'b1); wait_idle();
    issue(0, 2'b11, 32'h00, 32'h0, 1'b1); wait_idle();
    issue(1, 2'b01, 32'h11, 32'h0, 1'b1); wait_idle();
    issue(0, 2'b10, 32'h12, 32'h0, 1'b1); wait_idle();

    // Leave rr_ptr at 1, then reset in WAIT and confirm the search restarts at port 0.
    issue(0, 2'b10, 32'h10, 32'hA1B2_C3D4, 1'b0); wait_idle();
    issue(0, 2'b10, 32'h10, 32'hA1B2_C3D4, 1'b0);
    @(posedge clk); #2;
    check("in_wait", {63'b0, busy}, 64'h1);
    set_port(1, 2'b10, 32'h14, 32'h0BAD_F00D, 1'b0);
    req_valid = 2'b11;
    rst = 1'b1;
    sb_q.delete(); ma_q.delete();
    #1;
    check("rst_mid_ctrl", {57'b0, req_ready, resp_valid, resp_err, mem_en, busy}, 64'h0);
    check("rst_mid_data", {resp_data, mem_addr}, 64'h0);
    hs_log.delete(); hs_cyc_log.delete(); resp_cyc_log.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (hs_log.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("post_rst_count", 64'(hs_log.size()), 64'd2);
    if (hs_log.size() == 2) begin
      check("post_rst_grant0", 64'(hs_log[0]), 64'd0);
      check("post_rst_grant1", 64'(hs_log[1]), 64'd1);
    end
    wait_idle();

    // Latency 4 instance: response at T+6, busy high T+1..T+6
    @(posedge clk); #1;
    req_size4 = 4'b0010;
    req_addr4 = {32'h0, 32'h40};
    req_valid4 = 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready4[0] && n < 50);
    check("l4_handshake", {63'b0, req_ready4[0]}, 64'h1);
    t = cyc;
    @(posedge clk); #1;
    req_valid4 = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clk);
      else @(negedge clk);
      check("l4_cycle_index", 64'(cyc), 64'(t + k));
      check("l4_busy", {63'b0, busy4}, {63'b0, (k <= 6)});
      check("l4_mem_en", {63'b0, mem_en4}, {63'b0, (k == 1)});
      check("l4_resp_valid", {62'b0, resp_valid4}, (k == 6) ? 64'h1 : 64'h0);
      if (k == 1) check("l4_mem_addr", {32'b0, mem_addr4}, 64'h40);
      if (k == 6) begin
        check("l4_resp_data", {32'b0, resp_data4}, 64'h1234_5678);
        check("l4_resp_err", {63'b0, resp_err4}, 64'h0);
      end
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("ma_empty", 64'(ma_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
